// File: rtl/btb_upd_ctrl_pkg.sv
// Shared fetch-side definitions for the BTB update controller: table geometry,
// branch type encodings, retire-queue entry layout and controller states.
package btb_upd_ctrl_pkg;

  localparam int unsigned BTB_IDX_W   = 8;
  localparam int unsigned BTB_ENTRIES = 256;

  localparam logic [1:0] BR_COND = 2'd0;
  localparam logic [1:0] BR_JUMP = 2'd1;
  localparam logic [1:0] BR_CALL = 2'd2;
  localparam logic [1:0] BR_RET  = 2'd3;

  localparam int unsigned RT_ENTRY_W = 129;

  typedef struct packed {
    logic        brdir;
    logic [63:0] brpc;
    logic [63:0] taken_addr;
  } rt_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } upd_state_e;

endpackage

// File: rtl/btb_rt_fifo.sv
// Synchronous retire-update queue with full/empty flags and a clear that
// overrides any same-cycle push or pop.
module btb_rt_fifo
  import btb_upd_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      clear_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  rt_entry_t wdata_i,
  output rt_entry_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  rt_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/btb_upd_ctrl.sv
// BTB write-port scheduler: fetch1 allocations, queued retire updates and a
// full-table invalidate sweep share one registered write interface.
// Optional retire starvation guard: define BTB_UPD_STARVE_GUARD_EN.
module btb_upd_ctrl
  import btb_upd_ctrl_pkg::*;
#(
  parameter int unsigned RT_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sp_req_i,
  input  logic [2:0]           sp_brpos_i,
  input  logic [1:0]           sp_brtyp_i,
  input  logic [1:0]           sp_ras_ctl_i,
  input  logic [63:0]          sp_brpc_i,
  input  logic [63:0]          sp_brtar_i,
  input  logic                 rt_req_i,
  input  logic                 rt_brdir_i,
  input  logic [63:0]          rt_brpc_i,
  input  logic [63:0]          rt_taken_addr_i,
  output logic                 rt_full_o,
  input  logic                 flush_req_i,
  output logic                 flush_busy_o,
  output logic                 sp_drop_o,
  output logic                 rt_drop_o,
  output logic                 btb_sp_we_o,
  output logic [2:0]           btb_sp_brpos_o,
  output logic [1:0]           btb_sp_brtyp_o,
  output logic [1:0]           btb_sp_ras_ctl_o,
  output logic [63:0]          btb_sp_brpc_o,
  output logic [63:0]          btb_sp_brtar_o,
  output logic                 btb_rt_we_o,
  output logic                 btb_rt_brdir_o,
  output logic [63:0]          btb_rt_brpc_o,
  output logic [63:0]          btb_taken_addr_o,
  output logic                 btb_inv_we_o,
  output logic [BTB_IDX_W-1:0] btb_inv_idx_o
);

  upd_state_e           state_q;
  logic [BTB_IDX_W-1:0] inv_idx_q;
  logic                 inv_we_q;
  logic                 sp_we_q, rt_we_q, sp_drop_q, rt_drop_q;
  logic [2:0]           sp_brpos_q;
  logic [1:0]           sp_brtyp_q, sp_ras_ctl_q;
  logic [63:0]          sp_brpc_q, sp_brtar_q;
  rt_entry_t            rt_out_q;

  rt_entry_t fifo_wdata, fifo_head;
  logic      fifo_full, fifo_empty;
  logic      in_idle, arb_ok, start_flush, force_rt;
  logic      sp_win, do_pop, do_push;

  assign in_idle     = (state_q == ST_IDLE);
  assign start_flush = in_idle && flush_req_i;
  // A same-cycle flush request takes the port away from both requesters.
  assign arb_ok      = in_idle && !flush_req_i;
  assign sp_win      = arb_ok && sp_req_i && !force_rt;
  assign do_pop      = arb_ok && !fifo_empty && (!sp_req_i || force_rt);
  assign do_push     = arb_ok && rt_req_i && !fifo_full;
  assign fifo_wdata  = '{brdir: rt_brdir_i, brpc: rt_brpc_i, taken_addr: rt_taken_addr_i};

`ifdef BTB_UPD_STARVE_GUARD_EN
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  logic [STV_W-1:0] starve_q, starve_d;

  assign force_rt = !fifo_empty && (starve_q == STV_W'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!arb_ok || fifo_empty || do_pop) starve_d = '0;
    else if (sp_win)                     starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign force_rt = 1'b0;
`endif

  btb_rt_fifo #(.DEPTH(RT_DEPTH)) u_rt_fifo (
    .clock   (clock),
    .reset   (reset),
    .clear_i (start_flush),
    .push_i  (do_push),
    .pop_i   (do_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Controller FSM with every write-port and pulse output registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      inv_idx_q    <= '0;
      inv_we_q     <= 1'b0;
      sp_we_q      <= 1'b0;
      rt_we_q      <= 1'b0;
      sp_drop_q    <= 1'b0;
      rt_drop_q    <= 1'b0;
      sp_brpos_q   <= '0;
      sp_brtyp_q   <= '0;
      sp_ras_ctl_q <= '0;
      sp_brpc_q    <= '0;
      sp_brtar_q   <= '0;
      rt_out_q     <= '0;
    end else begin
      sp_we_q   <= sp_win;
      rt_we_q   <= do_pop;
      sp_drop_q <= sp_req_i && !sp_win;
      rt_drop_q <= rt_req_i && !do_push;
      if (sp_win) begin
        sp_brpos_q   <= sp_brpos_i;
        sp_brtyp_q   <= sp_brtyp_i;
        sp_ras_ctl_q <= sp_ras_ctl_i;
        sp_brpc_q    <= sp_brpc_i;
        sp_brtar_q   <= sp_brtar_i;
      end
      if (do_pop) rt_out_q <= fifo_head;
      case (state_q)
        ST_IDLE: begin
          if (flush_req_i) begin
            state_q   <= ST_FLUSH;
            inv_we_q  <= 1'b1;
            inv_idx_q <= '0;
          end
        end
        ST_FLUSH: begin
          if (inv_idx_q == BTB_IDX_W'(BTB_ENTRIES - 1)) begin
            state_q   <= ST_IDLE;
            inv_we_q  <= 1'b0;
            inv_idx_q <= '0;
          end else begin
            inv_idx_q <= inv_idx_q + 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          inv_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign rt_full_o        = fifo_full || (state_q == ST_FLUSH);
  assign flush_busy_o     = (state_q == ST_FLUSH);
  assign sp_drop_o        = sp_drop_q;
  assign rt_drop_o        = rt_drop_q;
  assign btb_sp_we_o      = sp_we_q;
  assign btb_sp_brpos_o   = sp_brpos_q;
  assign btb_sp_brtyp_o   = sp_brtyp_q;
  assign btb_sp_ras_ctl_o = sp_ras_ctl_q;
  assign btb_sp_brpc_o    = sp_brpc_q;
  assign btb_sp_brtar_o   = sp_brtar_q;
  assign btb_rt_we_o      = rt_we_q;
  assign btb_rt_brdir_o   = rt_out_q.brdir;
  assign btb_rt_brpc_o    = rt_out_q.brpc;
  assign btb_taken_addr_o = rt_out_q.taken_addr;
  assign btb_inv_we_o     = inv_we_q;
  assign btb_inv_idx_o    = inv_idx_q;

endmodule

// File: tb/tb_btb_upd_ctrl.sv
// Directed bench for btb_upd_ctrl; expectations follow BTB_UPD_STARVE_GUARD_EN
// when it is defined for the build.
module tb_btb_upd_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sp_req_i = 1'b0;
  logic [2:0]  sp_brpos_i = '0;
  logic [1:0]  sp_brtyp_i = '0;
  logic [1:0]  sp_ras_ctl_i = '0;
  logic [63:0] sp_brpc_i = '0;
  logic [63:0] sp_brtar_i = '0;
  logic        rt_req_i = 1'b0;
  logic        rt_brdir_i = 1'b0;
  logic [63:0] rt_brpc_i = '0;
  logic [63:0] rt_taken_addr_i = '0;
  logic        flush_req_i = 1'b0;
  logic        rt_full_o, flush_busy_o, sp_drop_o, rt_drop_o;
  logic        btb_sp_we_o, btb_rt_we_o, btb_rt_brdir_o, btb_inv_we_o;
  logic [2:0]  btb_sp_brpos_o;
  logic [1:0]  btb_sp_brtyp_o, btb_sp_ras_ctl_o;
  logic [63:0] btb_sp_brpc_o, btb_sp_brtar_o, btb_rt_brpc_o, btb_taken_addr_o;
  logic [7:0]  btb_inv_idx_o;

  int vectors = 0;
  int miscompares = 0;

  // Control bits in order: sp_we, rt_we, inv_we, sp_drop, rt_drop, rt_full, flush_busy.
  wire [6:0] ctl = {btb_sp_we_o, btb_rt_we_o, btb_inv_we_o, sp_drop_o, rt_drop_o,
                    rt_full_o, flush_busy_o};

  btb_upd_ctrl #(.RT_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clock            (clock),
    .reset            (reset),
    .sp_req_i         (sp_req_i),
    .sp_brpos_i       (sp_brpos_i),
    .sp_brtyp_i       (sp_brtyp_i),
    .sp_ras_ctl_i     (sp_ras_ctl_i),
    .sp_brpc_i        (sp_brpc_i),
    .sp_brtar_i       (sp_brtar_i),
    .rt_req_i         (rt_req_i),
    .rt_brdir_i       (rt_brdir_i),
    .rt_brpc_i        (rt_brpc_i),
    .rt_taken_addr_i  (rt_taken_addr_i),
    .rt_full_o        (rt_full_o),
    .flush_req_i      (flush_req_i),
    .flush_busy_o     (flush_busy_o),
    .sp_drop_o        (sp_drop_o),
    .rt_drop_o        (rt_drop_o),
    .btb_sp_we_o      (btb_sp_we_o),
    .btb_sp_brpos_o   (btb_sp_brpos_o),
    .btb_sp_brtyp_o   (btb_sp_brtyp_o),
    .btb_sp_ras_ctl_o (btb_sp_ras_ctl_o),
    .btb_sp_brpc_o    (btb_sp_brpc_o),
    .btb_sp_brtar_o   (btb_sp_brtar_o),
    .btb_rt_we_o      (btb_rt_we_o),
    .btb_rt_brdir_o   (btb_rt_brdir_o),
    .btb_rt_brpc_o    (btb_rt_brpc_o),
    .btb_taken_addr_o (btb_taken_addr_o),
    .btb_inv_we_o     (btb_inv_we_o),
    .btb_inv_idx_o    (btb_inv_idx_o)
  );

  always #5 clock = ~clock;

  // Outputs are observed 1 time unit after the edge that produced them.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    sp_req_i = 1'b0;
    rt_req_i = 1'b0;
    flush_req_i = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_rt(input int k);
    rt_brdir_i = k[0];
    rt_brpc_i = 64'h100 + 64'(k) * 64'h10;
    rt_taken_addr_i = 64'h8000 + 64'(k);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sp_req_i = 1'b1;
    rt_req_i = 1'b1;
    flush_req_i = 1'b1;
    sp_brpc_i = 64'hABCD;
    set_rt(3);
    step();
    step();
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++;
      $display("[TB] FAIL reset_ctl got %b want %b", ctl, 7'b0000000);
    end
    vectors++;
    if (btb_inv_idx_o !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_idx got %0d want 0", btb_inv_idx_o);
    end
    vectors++;
    if (btb_sp_brpc_o !== 64'h0 || btb_rt_brpc_o !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_fields got sp %h rt %h want 0 0", btb_sp_brpc_o, btb_rt_brpc_o);
    end
    do_reset();
  endtask

  task automatic test_spec_alloc();
    do_reset();
    step();
    step();
    sp_req_i = 1'b1;
    sp_brpos_i = 3'd5;
    sp_brtyp_i = 2'd2;
    sp_ras_ctl_i = 2'd1;
    sp_brpc_i = 64'h1000;
    sp_brtar_i = 64'h2000;
    step();
    sp_req_i = 1'b0;
    sp_brpc_i = 64'hDEAD;
    vectors++;
    if (ctl !== 7'b1000000) begin
      miscompares++;
      $display("[TB] FAIL spec_we got %b want %b", ctl, 7'b1000000);
    end
    vectors++;
    if ({btb_sp_brpos_o, btb_sp_brtyp_o, btb_sp_ras_ctl_o} !== {3'd5, 2'd2, 2'd1} ||
        btb_sp_brpc_o !== 64'h1000 || btb_sp_brtar_o !== 64'h2000) begin
      miscompares++;
      $display("[TB] FAIL spec_fields got pos %0d typ %0d ras %0d pc %h tar %h want 5 2 1 1000 2000",
               btb_sp_brpos_o, btb_sp_brtyp_o, btb_sp_ras_ctl_o, btb_sp_brpc_o, btb_sp_brtar_o);
    end
    step();
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++;
      $display("[TB] FAIL spec_one_cycle got %b want %b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    sp_req_i = 1'b1;
    sp_brpc_i = 64'h3000;
    sp_brtar_i = 64'h4000;
    step();
    sp_brpc_i = 64'h5000;
    sp_brtar_i = 64'h6000;
    vectors++;
    if (ctl !== 7'b1000000 || btb_sp_brpc_o !== 64'h3000 || btb_sp_brtar_o !== 64'h4000) begin
      miscompares++;
      $display("[TB] FAIL b2b_first got ctl %b pc %h tar %h want 1000000 3000 4000",
               ctl, btb_sp_brpc_o, btb_sp_brtar_o);
    end
    step();
    sp_req_i = 1'b0;
    vectors++;
    if (ctl !== 7'b1000000 || btb_sp_brpc_o !== 64'h5000 || btb_sp_brtar_o !== 64'h6000) begin
      miscompares++;
      $display("[TB] FAIL b2b_second got ctl %b pc %h tar %h want 1000000 5000 6000",
               ctl, btb_sp_brpc_o, btb_sp_brtar_o);
    end
  endtask

  task automatic test_retire_fill();
    logic [6:0] exp_ctl [5];
    exp_ctl[0] = 7'b0000000;
    exp_ctl[1] = 7'b1000000;
    exp_ctl[2] = 7'b1000000;
    exp_ctl[3] = 7'b1000010;
    exp_ctl[4] = 7'b0100100;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      rt_req_i = 1'b1;
      set_rt(k);
      sp_req_i = (k >= 1 && k <= 3);
      sp_brpc_i = 64'h7000 + 64'(k);
      step();
      vectors++;
      if (ctl !== exp_ctl[k]) begin
        miscompares++;
        $display("[TB] FAIL fill_ctl_%0d got %b want %b", k, ctl, exp_ctl[k]);
      end
    end
    rt_req_i = 1'b0;
    sp_req_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      vectors++;
      if (btb_rt_we_o !== 1'b1 || btb_rt_brdir_o !== j[0] ||
          btb_rt_brpc_o !== 64'h100 + 64'(j) * 64'h10 ||
          btb_taken_addr_o !== 64'h8000 + 64'(j)) begin
        miscompares++;
        $display("[TB] FAIL drain_%0d got we %b dir %b pc %h taken %h want 1 %b %h %h",
                 j, btb_rt_we_o, btb_rt_brdir_o, btb_rt_brpc_o, btb_taken_addr_o,
                 j[0], 64'h100 + 64'(j) * 64'h10, 64'h8000 + 64'(j));
      end
      step();
    end
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++;
      $display("[TB] FAIL drain_done got %b want %b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_starve();
    logic [6:0] exp5, exp6;
`ifdef BTB_UPD_STARVE_GUARD_EN
    exp5 = 7'b0101000;
    exp6 = 7'b0000000;
`else
    exp5 = 7'b1000000;
    exp6 = 7'b0100000;
`endif
    do_reset();
    rt_req_i = 1'b1;
    rt_brdir_i = 1'b1;
    rt_brpc_i = 64'hA0;
    rt_taken_addr_i = 64'hB0;
    sp_req_i = 1'b1;
    sp_brpc_i = 64'h9000;
    step();
    rt_req_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (ctl !== 7'b1000000) begin
        miscompares++;
        $display("[TB] FAIL starve_sp_%0d got %b want %b", i, ctl, 7'b1000000);
      end
      step();
    end
    sp_req_i = 1'b0;
    vectors++;
    if (ctl !== exp5) begin
      miscompares++;
      $display("[TB] FAIL starve_limit got %b want %b", ctl, exp5);
    end
    vectors++;
    if (btb_rt_we_o && btb_rt_brpc_o !== 64'hA0) begin
      miscompares++;
      $display("[TB] FAIL starve_entry got %h want a0", btb_rt_brpc_o);
    end
    step();
    vectors++;
    if (ctl !== exp6) begin
      miscompares++;
      $display("[TB] FAIL starve_after got %b want %b", ctl, exp6);
    end
    step();
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++;
      $display("[TB] FAIL starve_quiet got %b want %b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_flush();
    logic [6:0] exp_ctl;
    do_reset();
    rt_req_i = 1'b1;
    set_rt(10);
    step();
    set_rt(11);
    sp_req_i = 1'b1;
    step();
    rt_req_i = 1'b0;
    sp_req_i = 1'b0;
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    for (int k = 0; k < 256; k++) begin
      exp_ctl = (k == 8) ? 7'b0011111 : 7'b0010011;
      vectors++;
      if (ctl !== exp_ctl || btb_inv_idx_o !== 8'(k)) begin
        miscompares++;
        $display("[TB] FAIL flush_%0d got ctl %b idx %0d want %b %0d",
                 k, ctl, btb_inv_idx_o, exp_ctl, k);
      end
      sp_req_i = (k == 7);
      rt_req_i = (k == 7);
      flush_req_i = (k == 7);
      step();
    end
    sp_req_i = 1'b0;
    rt_req_i = 1'b0;
    flush_req_i = 1'b0;
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++;
      $display("[TB] FAIL flush_end got %b want %b", ctl, 7'b0000000);
    end
    sp_req_i = 1'b1;
    sp_brpc_i = 64'hE000;
    step();
    sp_req_i = 1'b0;
    vectors++;
    if (ctl !== 7'b1000000 || btb_sp_brpc_o !== 64'hE000) begin
      miscompares++;
      $display("[TB] FAIL flush_resume got ctl %b pc %h want 1000000 e000", ctl, btb_sp_brpc_o);
    end
    step();
    step();
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++;
      $display("[TB] FAIL flush_no_stale got %b want %b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    repeat (100) step();
    vectors++;
    if (ctl !== 7'b0010011 || btb_inv_idx_o !== 8'd100) begin
      miscompares++;
      $display("[TB] FAIL freset_idx got ctl %b idx %0d want 0010011 100", ctl, btb_inv_idx_o);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (ctl !== 7'b0000000 || btb_inv_idx_o !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL freset_clear got ctl %b idx %0d want 0000000 0", ctl, btb_inv_idx_o);
    end
    sp_req_i = 1'b1;
    sp_brpc_i = 64'hF000;
    step();
    sp_req_i = 1'b0;
    vectors++;
    if (ctl !== 7'b1000000 || btb_sp_brpc_o !== 64'hF000) begin
      miscompares++;
      $display("[TB] FAIL freset_sp got ctl %b pc %h want 1000000 f000", ctl, btb_sp_brpc_o);
    end
  endtask

  task automatic test_flush_collision();
    do_reset();
    flush_req_i = 1'b1;
    sp_req_i = 1'b1;
    rt_req_i = 1'b1;
    sp_brpc_i = 64'h1234;
    step();
    flush_req_i = 1'b0;
    sp_req_i = 1'b0;
    rt_req_i = 1'b0;
    vectors++;
    if (ctl !== 7'b0011111 || btb_inv_idx_o !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL collide got ctl %b idx %0d want 0011111 0", ctl, btb_inv_idx_o);
    end
    step();
    vectors++;
    if (ctl !== 7'b0010011 || btb_inv_idx_o !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL collide_next got ctl %b idx %0d want 0010011 1", ctl, btb_inv_idx_o);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_spec_alloc();
    test_back_to_back();
    test_retire_fill();
    test_starve();
    test_flush();
    test_flush_reset();
    test_flush_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
